execute_mc_unit: RTL and testbench

- Parametrised next-generation execute stage for the pipelined core.
- Selects forwarded operands from EX/MEM and MEM/WB, then executes single-cycle ALU and set-condition ops with a registered result.
- Adds iterative multi-cycle MUL/DIVU/REMU, which stalls the front of the pipe through a ready/valid handshake.
- Output register acts as the EX/MEM result register.

---
 rtl/execute_mc_unit_pkg.sv | 41 ++++
 rtl/execute_mc_unit_if.sv | 44 ++++
 rtl/execute_mc_unit_muldiv_iter.sv | 111 +++++++++++
 rtl/execute_mc_unit.sv | 188 ++++++++++++++++++
 tb/tb_execute_mc_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_mc_unit_pkg.sv
// Shared encodings for the execute stage: opcodes, FSM states, forward-select and iterative-unit op.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package execute_mc_unit_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_SLL   = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd5;
    localparam logic [3:0] OP_ROL   = 4'd6;
    localparam logic [3:0] OP_ROR   = 4'd7;
    localparam logic [3:0] OP_SEQ   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_SLE   = 4'd10;
    localparam logic [3:0] OP_SCO   = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REMU  = 4'd14;
    localparam logic [3:0] OP_PASSB = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Also consumed by the hazard unit, so keep the encoding stable.
    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REMU = 2'd2
    } md_op_e;

endpackage

// File: rtl/execute_mc_unit_if.sv
// Operand/forwarding/result bundle between the issue logic and the execute stage.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready handshake on the issue side; result side is a valid pulse.
interface execute_mc_unit_if #(
    parameter int WIDTH     = 16,
    parameter int REG_IDX_W = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 flush;
    logic [3:0]           op;
    logic [REG_IDX_W-1:0] rs_idx;
    logic [REG_IDX_W-1:0] rt_idx;
    logic                 rs_used;
    logic                 rt_used;
    logic [WIDTH-1:0]     rs_data;
    logic [WIDTH-1:0]     rt_data;
    logic [WIDTH-1:0]     imm;
    logic                 use_imm;
    logic [REG_IDX_W-1:0] exmem_rd;
    logic [REG_IDX_W-1:0] memwb_rd;
    logic                 exmem_wr;
    logic                 memwb_wr;
    logic [WIDTH-1:0]     exmem_data;
    logic [WIDTH-1:0]     memwb_data;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_result;
    logic                 out_zero;
    logic                 out_ltz;
    logic                 out_ofl;
    logic                 out_err;

    modport master (
        output in_valid, flush, op, rs_idx, rt_idx, rs_used, rt_used, rs_data, rt_data,
               imm, use_imm, exmem_rd, memwb_rd, exmem_wr, memwb_wr, exmem_data, memwb_data,
        input  in_ready, out_valid, out_result, out_zero, out_ltz, out_ofl, out_err
    );

    modport slave (
        input  in_valid, flush, op, rs_idx, rt_idx, rs_used, rt_used, rs_data, rt_data,
               imm, use_imm, exmem_rd, memwb_rd, exmem_wr, memwb_wr, exmem_data, memwb_data,
        output in_ready, out_valid, out_result, out_zero, out_ltz, out_ofl, out_err
    );
endinterface

// File: rtl/execute_mc_unit_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per clock.
// Latency: WIDTH edges after start; done_o marks the final iteration edge, result_o valid then.
// Backpressure: none internally; caller must not start while busy_o, abort_i cancels immediately.
module execute_mc_unit_muldiv_iter
    import execute_mc_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  md_op_e           op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             ofl_o
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic               busy_q;
    md_op_e             op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   divisor_q;

    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_sub;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quot_d;

    // One multiply step (conditional add) and one restoring-divide step (trial subtract).
    always_comb begin
        prod_d    = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        rem_shift = {rem_q, quot_q[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, divisor_q};
        // Top bit of the trial difference is set exactly when the divisor did not fit.
        if (!rem_sub[WIDTH]) begin
            rem_d  = rem_sub[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d  = rem_shift[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
    end

    // Result of the step being taken now; sampled by the caller on the final iteration edge.
    always_comb begin
        ofl_o = 1'b0;
        case (op_q)
            MD_MUL: begin
                result_o = prod_d[WIDTH-1:0];
                ofl_o    = |prod_d[2*WIDTH-1:WIDTH];
            end
            MD_DIVU: result_o = quot_d;
            default: result_o = rem_d;
        endcase
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == LAST);

    // Operand latch at start, then one iteration per clock until the counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            op_q      <= MD_MUL;
            cnt_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q    <= 1'b1;
            op_q      <= op_i;
            cnt_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= {{WIDTH{1'b0}}, a_i};
            mplier_q  <= b_i;
            rem_q     <= '0;
            quot_q    <= a_i;
            divisor_q <= b_i;
        end else if (busy_q) begin
            prod_q   <= prod_d;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/execute_mc_unit.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MUL/DIVU/REMU, EX/MEM result register.
// Latency: 1 edge for single-cycle ops and divide-by-zero, WIDTH edges after accept for MUL/DIVU/REMU.
// Backpressure: in_ready drops for WIDTH cycles after a multi-cycle accept; flush drops input or aborts.
module execute_mc_unit
    import execute_mc_unit_pkg::*;
#(
    parameter int WIDTH     = 16,   // power of two, at least 4
    parameter int REG_IDX_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    execute_mc_unit_if.slave  bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    fwd_sel_e           rs_sel;
    fwd_sel_e           rt_sel;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   rt_fwd;
    logic [WIDTH-1:0]   op_b;
    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W:0]   inv_shamt;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ofl;
    logic               is_mc;
    logic               div_zero;
    logic               accept;
    logic               mc_start;
    md_op_e             md_op_sel;
    logic               md_busy;
    logic               md_done;
    logic [WIDTH-1:0]   md_result;
    logic               md_ofl;

    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_result_q;
    logic               out_zero_q;
    logic               out_ltz_q;
    logic               out_ofl_q;
    logic               out_err_q;

    // Forward-select per source: EX/MEM beats MEM/WB, index 0 is an ordinary register.
    always_comb begin
        rs_sel = FWD_RF;
        rt_sel = FWD_RF;
        if (bus.rs_used && bus.exmem_wr && (bus.exmem_rd == bus.rs_idx))      rs_sel = FWD_EXMEM;
        else if (bus.rs_used && bus.memwb_wr && (bus.memwb_rd == bus.rs_idx)) rs_sel = FWD_MEMWB;
        if (bus.rt_used && bus.exmem_wr && (bus.exmem_rd == bus.rt_idx))      rt_sel = FWD_EXMEM;
        else if (bus.rt_used && bus.memwb_wr && (bus.memwb_rd == bus.rt_idx)) rt_sel = FWD_MEMWB;
    end

    // Operand muxes driven by the forward-select codes.
    always_comb begin
        case (rs_sel)
            FWD_EXMEM: op_a = bus.exmem_data;
            FWD_MEMWB: op_a = bus.memwb_data;
            default:   op_a = bus.rs_data;
        endcase
        case (rt_sel)
            FWD_EXMEM: rt_fwd = bus.exmem_data;
            FWD_MEMWB: rt_fwd = bus.memwb_data;
            default:   rt_fwd = bus.rt_data;
        endcase
        op_b = bus.use_imm ? bus.imm : rt_fwd;
    end

    assign shamt     = op_b[SHAMT_W-1:0];
    // Shifting by a full WIDTH yields zero, which makes a rotate by 0 return A unchanged.
    assign inv_shamt = (SHAMT_W + 1)'(WIDTH) - {1'b0, shamt};
    assign sum_ext   = {1'b0, op_a} + {1'b0, op_b};
    assign diff      = op_a - op_b;

    // Single-cycle ALU; DIVU/REMU entries only matter on the divide-by-zero shortcut.
    always_comb begin
        alu_res = '0;
        alu_ofl = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_ofl = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ofl = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND:   alu_res = op_a & op_b;
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_SLL:   alu_res = op_a << shamt;
            OP_SRL:   alu_res = op_a >> shamt;
            OP_ROL:   alu_res = (op_a << shamt) | (op_a >> inv_shamt);
            OP_ROR:   alu_res = (op_a >> shamt) | (op_a << inv_shamt);
            OP_SEQ:   alu_res = {{(WIDTH-1){1'b0}}, op_a == op_b};
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLE:   alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) <= $signed(op_b)};
            OP_SCO:   alu_res = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH]};
            OP_DIVU:  alu_res = '1;
            OP_REMU:  alu_res = op_a;
            OP_PASSB: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    // Accept decode; a zero divisor skips the iterative unit entirely.
    always_comb begin
        is_mc     = (bus.op == OP_MUL) || (bus.op == OP_DIVU) || (bus.op == OP_REMU);
        div_zero  = ((bus.op == OP_DIVU) || (bus.op == OP_REMU)) && (op_b == '0);
        accept    = bus.in_valid && in_ready_q && !bus.flush;
        mc_start  = accept && is_mc && !div_zero;
        md_op_sel = (bus.op == OP_MUL) ? MD_MUL : ((bus.op == OP_DIVU) ? MD_DIVU : MD_REMU);
    end

    execute_mc_unit_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mc_start),
        .abort_i  (bus.flush && md_busy),
        .op_i     (md_op_sel),
        .a_i      (op_a),
        .b_i      (op_b),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result),
        .ofl_o    (md_ofl)
    );

    // IDLE/BUSY control plus the EX/MEM result register; outputs hold unless a result lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_zero_q   <= 1'b0;
            out_ltz_q    <= 1'b0;
            out_ofl_q    <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (mc_start) begin
                            state_q    <= ST_BUSY;
                            in_ready_q <= 1'b0;
                            out_err_q  <= 1'b0;
                        end else begin
                            out_valid_q  <= 1'b1;
                            out_result_q <= alu_res;
                            out_zero_q   <= (alu_res == '0);
                            out_ltz_q    <= alu_res[WIDTH-1];
                            out_ofl_q    <= alu_ofl;
                            out_err_q    <= div_zero;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.flush) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                    end else if (md_done) begin
                        state_q      <= ST_IDLE;
                        in_ready_q   <= 1'b1;
                        out_valid_q  <= 1'b1;
                        out_result_q <= md_result;
                        out_zero_q   <= (md_result == '0);
                        out_ltz_q    <= md_result[WIDTH-1];
                        out_ofl_q    <= md_ofl;
                        out_err_q    <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_ltz    = out_ltz_q;
    assign bus.out_ofl    = out_ofl_q;
    assign bus.out_err    = out_err_q;

endmodule

// File: tb/tb_execute_mc_unit.sv
// Directed plus randomized bench for execute_mc_unit against a behavioural model.
// Latency: checks 1-edge and WIDTH-edge completion, in_ready low window and single out_valid pulse.
// Backpressure: exercises in_ready stall, flush in IDLE/BUSY and reset mid-operation.
module tb_execute_mc_unit;
    import execute_mc_unit_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execute_mc_unit_if #(.WIDTH(W), .REG_IDX_W(3)) bus ();
    execute_mc_unit #(.WIDTH(W), .REG_IDX_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rs_idx, rt_idx, ex_rd, mw_rd;
        logic        rs_used, rt_used, use_imm, ex_wr, mw_wr;
        logic [15:0] rs_data, rt_data, imm, ex_data, mw_data;
    } req_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic req_t simple(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        req_t q;
        q.op = o;       q.rs_idx = 3'd1; q.rt_idx = 3'd2; q.ex_rd = 3'd0; q.mw_rd = 3'd0;
        q.rs_used = 1'b1; q.rt_used = 1'b0; q.use_imm = 1'b1; q.ex_wr = 1'b0; q.mw_wr = 1'b0;
        q.rs_data = a;  q.rt_data = 16'h0; q.imm = b; q.ex_data = 16'h0; q.mw_data = 16'h0;
        return q;
    endfunction

    task automatic apply(input req_t q);
        bus.op = q.op;           bus.rs_idx = q.rs_idx;   bus.rt_idx = q.rt_idx;
        bus.rs_used = q.rs_used; bus.rt_used = q.rt_used; bus.use_imm = q.use_imm;
        bus.rs_data = q.rs_data; bus.rt_data = q.rt_data; bus.imm = q.imm;
        bus.exmem_rd = q.ex_rd;  bus.exmem_wr = q.ex_wr;  bus.exmem_data = q.ex_data;
        bus.memwb_rd = q.mw_rd;  bus.memwb_wr = q.mw_wr;  bus.memwb_data = q.mw_data;
    endtask

    // Value a source sees after forwarding from the later pipeline stages.
    function automatic logic [15:0] fwd(input logic used, input logic [2:0] idx,
                                        input logic [15:0] rf, input req_t q);
        if (used && q.ex_wr && q.ex_rd == idx) return q.ex_data;
        if (used && q.mw_wr && q.mw_rd == idx) return q.mw_data;
        return rf;
    endfunction

    // Architectural result of one op; lat = extra edges after the accepting edge.
    function automatic void model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic ofl, output logic err,
                                  output int lat);
        int sa, sb, s, sh;
        longint unsigned p;
        sa = $signed(a); sb = $signed(b); sh = int'(b[3:0]);
        r = 16'h0; ofl = 1'b0; err = 1'b0; lat = 0;
        case (o)
            OP_ADD:  begin s = sa + sb; r = s[15:0]; ofl = (s > 32767) || (s < -32768); end
            OP_SUB:  begin s = sa - sb; r = s[15:0]; ofl = (s > 32767) || (s < -32768); end
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_ROL:  begin r = a; repeat (sh) r = {r[14:0], r[15]}; end
            OP_ROR:  begin r = a; repeat (sh) r = {r[0], r[15:1]}; end
            OP_SEQ:  r = (a == b) ? 16'd1 : 16'd0;
            OP_SLT:  r = (sa < sb) ? 16'd1 : 16'd0;
            OP_SLE:  r = (sa <= sb) ? 16'd1 : 16'd0;
            OP_SCO:  r = ((int'(a) + int'(b)) > 65535) ? 16'd1 : 16'd0;
            OP_MUL:  begin p = longint'(a) * longint'(b); r = p[15:0]; ofl = (p > 65535); lat = W; end
            OP_DIVU: if (b == 0) begin r = 16'hFFFF; err = 1'b1; end else begin r = a / b; lat = W; end
            OP_REMU: if (b == 0) begin r = a; err = 1'b1; end else begin r = a % b; lat = W; end
            default: r = b;
        endcase
    endfunction

    // Issue one op, then check latency, stall window, result/flags, pulse width and hold.
    task automatic run_req(input req_t q, input string tag, output logic [15:0] obs);
        logic [15:0] a, b, er;
        logic eofl, eerr;
        int elat, k, lowrdy;
        a = fwd(q.rs_used, q.rs_idx, q.rs_data, q);
        b = q.use_imm ? q.imm : fwd(q.rt_used, q.rt_idx, q.rt_data, q);
        model(q.op, a, b, er, eofl, eerr, elat);
        apply(q);
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 40) begin @(posedge clk); #1; k++; end
        chk({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        // Disturb every operand source; a latched multi-cycle op must not notice.
        bus.rs_data = ~q.rs_data; bus.rt_data = ~q.rt_data; bus.imm = ~q.imm;
        bus.exmem_data = ~q.ex_data; bus.memwb_data = ~q.mw_data;
        k = 0; lowrdy = 0;
        while (!bus.out_valid && k < 40) begin
            if (k == 0) chk({tag, "_errclr"}, {31'd0, bus.out_err}, 32'd0);
            if (!bus.in_ready) lowrdy++;
            @(posedge clk); #1; k++;
        end
        chk({tag, "_lat"}, k, elat);
        chk({tag, "_stall"}, lowrdy, elat);
        chk({tag, "_res"}, {16'd0, bus.out_result}, {16'd0, er});
        chk({tag, "_ofl"}, {31'd0, bus.out_ofl}, {31'd0, eofl});
        chk({tag, "_err"}, {31'd0, bus.out_err}, {31'd0, eerr});
        chk({tag, "_zero"}, {31'd0, bus.out_zero}, {31'd0, er == 16'h0});
        chk({tag, "_ltz"}, {31'd0, bus.out_ltz}, {31'd0, er[15]});
        chk({tag, "_rdyback"}, {31'd0, bus.in_ready}, 32'd1);
        obs = bus.out_result;
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_hold"}, {16'd0, bus.out_result}, {16'd0, er});
    endtask

    initial begin
        req_t q;
        logic [15:0] obs;
        int k, lowrdy;

        apply(simple(OP_ADD, 16'h0, 16'h0));
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_rdy", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_vld", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_res", {16'd0, bus.out_result}, 32'd0);
        chk("rst_flags", {28'd0, bus.out_zero, bus.out_ltz, bus.out_ofl, bus.out_err}, 32'd0);

        // Forwarding priority.
        q = simple(OP_ADD, 16'h0005, 16'h0001);
        q.rs_idx = 3'd2; q.ex_rd = 3'd2; q.ex_wr = 1'b1; q.ex_data = 16'h1111;
        q.mw_rd = 3'd2; q.mw_wr = 1'b1; q.mw_data = 16'h2222;
        run_req(q, "fwd_ex", obs);   chk("fwd_ex_c", {16'd0, obs}, 32'h1112);
        q.ex_wr = 1'b0;
        run_req(q, "fwd_mw", obs);   chk("fwd_mw_c", {16'd0, obs}, 32'h2223);
        q.rs_used = 1'b0;
        run_req(q, "fwd_rf", obs);   chk("fwd_rf_c", {16'd0, obs}, 32'h0006);
        q = simple(OP_PASSB, 16'h0, 16'h0);
        q.use_imm = 1'b0; q.rt_used = 1'b1; q.rt_idx = 3'd0;
        q.mw_rd = 3'd0; q.mw_wr = 1'b1; q.mw_data = 16'hBEEF;
        run_req(q, "fwd_r0", obs);   chk("fwd_r0_c", {16'd0, obs}, 32'hBEEF);

        // Overflow, compares, shifts and rotates.
        run_req(simple(OP_ADD, 16'h7FFF, 16'h0001), "add_ofl", obs); chk("add_ofl_c", {16'd0, obs}, 32'h8000);
        run_req(simple(OP_SLT, 16'hFFFF, 16'h0001), "slt", obs);     chk("slt_c", {16'd0, obs}, 32'h1);
        run_req(simple(OP_SCO, 16'hFFFF, 16'h0001), "sco", obs);     chk("sco_c", {16'd0, obs}, 32'h1);
        run_req(simple(OP_ROR, 16'h8001, 16'h0001), "ror", obs);     chk("ror_c", {16'd0, obs}, 32'hC000);
        run_req(simple(OP_ROL, 16'h8001, 16'h0004), "rol", obs);     chk("rol_c", {16'd0, obs}, 32'h0018);
        run_req(simple(OP_SRL, 16'h8000, 16'h000F), "srl", obs);     chk("srl_c", {16'd0, obs}, 32'h0001);
        run_req(simple(OP_ROR, 16'h1234, 16'h0000), "ror0", obs);    chk("ror0_c", {16'd0, obs}, 32'h1234);

        // MUL with an ADD waiting behind it.
        apply(simple(OP_MUL, 16'h00FF, 16'h0101));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        apply(simple(OP_ADD, 16'h0003, 16'h0004));
        k = 0; lowrdy = 0;
        while (!bus.out_valid && k < 40) begin
            if (!bus.in_ready) lowrdy++;
            @(posedge clk); #1; k++;
        end
        chk("mul_lat", k, W);
        chk("mul_stall", lowrdy, W);
        chk("mul_res", {16'd0, bus.out_result}, 32'hFFFF);
        chk("mul_ofl", {31'd0, bus.out_ofl}, 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("b2b_vld", {31'd0, bus.out_valid}, 32'd1);
        chk("b2b_res", {16'd0, bus.out_result}, 32'h0007);
        @(posedge clk); #1;
        chk("b2b_pulse", {31'd0, bus.out_valid}, 32'd0);

        // Division.
        run_req(simple(OP_DIVU, 16'd100, 16'd7), "divu", obs); chk("divu_c", {16'd0, obs}, 32'd14);
        run_req(simple(OP_REMU, 16'd100, 16'd7), "remu", obs); chk("remu_c", {16'd0, obs}, 32'd2);
        run_req(simple(OP_DIVU, 16'd5, 16'd0), "div0", obs);   chk("div0_c", {16'd0, obs}, 32'hFFFF);
        run_req(simple(OP_REMU, 16'd5, 16'd0), "rem0", obs);   chk("rem0_c", {16'd0, obs}, 32'd5);
        run_req(simple(OP_MUL, 16'h0100, 16'h0100), "mul_ofl", obs);

        // Flush in IDLE drops the input.
        apply(simple(OP_ADD, 16'h0001, 16'h0001));
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        chk("fidle_vld", {31'd0, bus.out_valid}, 32'd0);
        chk("fidle_rdy", {31'd0, bus.in_ready}, 32'd1);
        chk("fidle_hold", {16'd0, bus.out_result}, 32'h0000);

        // Flush in cycle 5 of a DIVU.
        apply(simple(OP_DIVU, 16'd100, 16'd7));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("fbusy_rdy", {31'd0, bus.in_ready}, 32'd1);
        chk("fbusy_vld", {31'd0, bus.out_valid}, 32'd0);
        k = 0;
        repeat (20) begin @(posedge clk); #1; if (bus.out_valid) k++; end
        chk("fbusy_novld", k, 0);
        run_req(simple(OP_ADD, 16'h1234, 16'h0001), "fbusy_add", obs);

        // Reset in cycle 8 of a MUL.
        apply(simple(OP_MUL, 16'h0003, 16'h0005));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rmul_rdy", {31'd0, bus.in_ready}, 32'd1);
        chk("rmul_vld", {31'd0, bus.out_valid}, 32'd0);
        chk("rmul_res", {16'd0, bus.out_result}, 32'd0);
        chk("rmul_flags", {28'd0, bus.out_zero, bus.out_ltz, bus.out_ofl, bus.out_err}, 32'd0);
        k = 0;
        repeat (20) begin @(posedge clk); #1; if (bus.out_valid) k++; end
        chk("rmul_novld", k, 0);

        // Randomized ops with random forwarding hazards.
        for (int i = 0; i < 40; i++) begin
            q.op = 4'($urandom_range(0, 15));
            q.rs_idx = 3'($urandom_range(0, 3)); q.rt_idx = 3'($urandom_range(0, 3));
            q.ex_rd = 3'($urandom_range(0, 3));  q.mw_rd = 3'($urandom_range(0, 3));
            q.rs_used = 1'($urandom); q.rt_used = 1'($urandom); q.use_imm = 1'($urandom);
            q.ex_wr = 1'($urandom); q.mw_wr = 1'($urandom);
            q.rs_data = 16'($urandom); q.rt_data = 16'($urandom); q.imm = 16'($urandom);
            q.ex_data = 16'($urandom); q.mw_data = 16'($urandom);
            if ((q.op == OP_DIVU || q.op == OP_REMU) && $urandom_range(0, 3) == 0) begin
                q.use_imm = 1'b1; q.imm = 16'h0;
            end
            run_req(q, $sformatf("rnd%0d", i), obs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
